// File: rtl/layer_4_maxpool2x2.sv
// 2x2 stride-2 FP32 max-pool over an IMG_SIZE x IMG_SIZE raster stream; optional ReLU via MAXPOOL_RELU_EN.
// Latency 1 clk after the 4th pixel of each window; no backpressure, idle cycles hold all state.
module layer_4_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int CW     = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int BW     = (CW > 1) ? CW - 1 : 1;
  localparam int HALF   = IMG_SIZE / 2;
  localparam int MAG_HI = DATA_WIDTH - 2;

  if (IMG_SIZE % 2 != 0) begin : g_odd_size
    $error("layer_4_maxpool2x2: IMG_SIZE must be even");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("layer_4_maxpool2x2: DATA_WIDTH must be 32 (FP32)");
  end

  // Sign-magnitude ordering on raw bits; +0/-0 compare equal; ties keep a.
  function automatic logic [DATA_WIDTH-1:0] fp_max(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [MAG_HI:0] mag_a;
    logic [MAG_HI:0] mag_b;
    logic            sgn_a;
    logic            sgn_b;
    mag_a = a[MAG_HI:0];
    mag_b = b[MAG_HI:0];
    sgn_a = a[DATA_WIDTH-1];
    sgn_b = b[DATA_WIDTH-1];
    if ((mag_a == '0) && (mag_b == '0)) begin
      return a;
    end
    if (sgn_a != sgn_b) begin
      return sgn_a ? b : a;
    end
    if (!sgn_a) begin
      return (mag_b > mag_a) ? b : a;
    end
    return (mag_b < mag_a) ? b : a;
  endfunction

  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic [DATA_WIDTH-1:0] held;
  logic [DATA_WIDTH-1:0] line_buf [HALF];

  logic [BW-1:0]         buf_idx;
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic [DATA_WIDTH-1:0] pool_res;
  logic                  col_last;
  logic                  row_last;
  logic                  row_odd;
  logic                  col_odd;

  assign buf_idx  = BW'(col >> 1);
  assign buf_rd   = line_buf[buf_idx];
  assign row_odd  = row[0];
  assign col_odd  = col[0];
  assign col_last = (col == CW'(IMG_SIZE - 1));
  assign row_last = (row == CW'(IMG_SIZE - 1));

  // The window's first pixel (held) pairs with the current one; the top pair
  // sits in the line buffer until the bottom row of the window arrives.
  assign pair_max = fp_max(held, data_in);
  assign win_max  = fp_max(buf_rd, pair_max);

`ifdef MAXPOOL_RELU_EN
  assign pool_res = win_max[DATA_WIDTH-1] ? '0 : win_max;
`else
  assign pool_res = win_max;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row       <= '0;
      col       <= '0;
      held      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col_odd) begin
          held <= data_in;
        end else if (row_odd) begin
          data_out  <= pool_res;
          valid_out <= 1'b1;
        end
      end
    end
  end

  // Contents need no reset: every entry is rewritten on an even row before
  // the odd row that reads it.
  always_ff @(posedge Clk) begin
    if (valid_in && col_odd && !row_odd) begin
      line_buf[buf_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_layer_4_maxpool2x2.sv
// Randomised bench for layer_4_maxpool2x2: a 4x4 and a 104x104 instance checked every cycle against a frame-level model.
module tb_layer_4_maxpool2x2;

  localparam int S_BIG = 104;
  localparam int N_BIG = S_BIG * S_BIG;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d4, d104, q4, q104;
  logic        v4, v104, o4, o104;

  always #5 clk = ~clk;

  layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut4 (
    .Clk(clk), .Rst(rst_n), .data_in(d4), .valid_in(v4),
    .data_out(q4), .valid_out(o4)
  );

  layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(S_BIG)) dut104 (
    .Clk(clk), .Rst(rst_n), .data_in(d104), .valid_in(v104),
    .data_out(q104), .valid_out(o104)
  );

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q_exp4[$];
  exp_t        q_exp104[$];
  logic [31:0] got4[$];
  int          got104_cnt;
  logic [31:0] last4, last104;
  logic [31:0] pix4 [16];
  logic [31:0] pix104 [N_BIG];
  int          idx4, idx104;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] ramp [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };
  logic [31:0] ramp_pool [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

  // Real-number ordering: map the bit pattern to a signed magnitude key.
  function automatic longint fp_key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    return (fp_key(b) > fp_key(a)) ? b : a;
  endfunction

  function automatic logic [31:0] ref_pool(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = ref_max(ref_max(a, b), ref_max(c, d));
`ifdef MAXPOOL_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_pix();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h0;
    else if ($urandom_range(0, 7) == 0) r = {$urandom_range(0, 1) == 1, 31'h3F800000};
    return r;
  endfunction

  task automatic model_beat4(input logic [31:0] d);
    pix4[idx4] = d;
    if (((idx4 / 4) % 2 == 1) && ((idx4 % 4) % 2 == 1))
      q_exp4.push_back('{ref_pool(pix4[idx4-5], pix4[idx4-4], pix4[idx4-1], d), cyc + 1});
    idx4 = (idx4 + 1) % 16;
  endtask

  task automatic model_beat104(input logic [31:0] d);
    pix104[idx104] = d;
    if (((idx104 / S_BIG) % 2 == 1) && ((idx104 % S_BIG) % 2 == 1))
      q_exp104.push_back('{ref_pool(pix104[idx104-S_BIG-1], pix104[idx104-S_BIG],
                                    pix104[idx104-1], d), cyc + 1});
    idx104 = (idx104 + 1) % N_BIG;
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic beat4(input logic [31:0] d);
    v4 = 1'b1;
    d4 = d;
    model_beat4(d);
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic beat104(input logic [31:0] d);
    v104 = 1'b1;
    d104 = d;
    model_beat104(d);
    @(negedge clk);
    v104 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_exp4.delete();
    q_exp104.delete();
    idx4    = 0;
    idx104  = 0;
    last4   = 32'h0;
    last104 = 32'h0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic expect_ramp(input string tag);
    n_checks++;
    if (got4.size() != 4) begin
      n_fail++;
      $display("FAIL %s_count: got %0d pulses, expected 4", tag, got4.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got4[k] !== ramp_pool[k]) begin
          n_fail++;
          $display("FAIL %s_val%0d: got %h, expected %h", tag, k, got4[k], ramp_pool[k]);
        end
      end
    end
  endtask

  task automatic expect_lit(input string tag, input int k, input logic [31:0] want);
    n_checks++;
    if (got4.size() <= k) begin
      n_fail++;
      $display("FAIL %s: only %0d outputs, expected %h at index %0d", tag, got4.size(), want, k);
    end else if (got4[k] !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got4[k], want);
    end
  endtask

  task automatic chk4();
    logic ev;
    ev = (q_exp4.size() > 0) && (q_exp4[0].due == cyc);
    n_checks++;
    if (o4 !== ev) begin
      n_fail++;
      $display("FAIL valid4 @%0d: got %b, expected %b", cyc, o4, ev);
    end
    if (ev) begin
      last4 = q_exp4[0].d;
      void'(q_exp4.pop_front());
    end
    if (o4 === 1'b1) got4.push_back(q4);
    n_checks++;
    if (q4 !== last4) begin
      n_fail++;
      $display("FAIL data4 @%0d: got %h, expected %h", cyc, q4, last4);
    end
  endtask

  task automatic chk104();
    logic ev;
    ev = (q_exp104.size() > 0) && (q_exp104[0].due == cyc);
    n_checks++;
    if (o104 !== ev) begin
      n_fail++;
      $display("FAIL valid104 @%0d: got %b, expected %b", cyc, o104, ev);
    end
    if (ev) begin
      last104 = q_exp104[0].d;
      void'(q_exp104.pop_front());
    end
    if (o104 === 1'b1) got104_cnt++;
    n_checks++;
    if (q104 !== last104) begin
      n_fail++;
      $display("FAIL data104 @%0d: got %h, expected %h", cyc, q104, last104);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    chk4();
    chk104();
  end

  initial begin
    logic [31:0] fr [16];
    rst_n      = 1'b0;
    v4         = 1'b0;
    d4         = 32'h0;
    v104       = 1'b0;
    d104       = 32'h0;
    got104_cnt = 0;
    last4      = 32'h0;
    last104    = 32'h0;
    idx4       = 0;
    idx104     = 0;
    @(negedge clk);
    do_reset();
    idle(2);

    // Ramp 1.0..16.0 at full rate.
    got4.delete();
    for (int i = 0; i < 16; i++) beat4(ramp[i]);
    idle(3);
    expect_ramp("ramp");

    // All-negative window and zero/mixed-sign windows.
    for (int i = 0; i < 16; i++) fr[i] = rand_pix();
    fr[0] = 32'hBF800000; fr[1] = 32'hC0000000; fr[4] = 32'hBF000000; fr[5] = 32'hC0400000;
    got4.delete();
    for (int i = 0; i < 16; i++) beat4(fr[i]);
    idle(3);
`ifdef MAXPOOL_RELU_EN
    expect_lit("neg_window", 0, 32'h00000000);
`else
    expect_lit("neg_window", 0, 32'hBF000000);
`endif

    for (int i = 0; i < 16; i++) fr[i] = rand_pix();
    fr[0] = 32'h00000000; fr[1] = 32'h80000000; fr[4] = 32'h80000000; fr[5] = 32'h00000000;
    fr[2] = 32'hC0800000; fr[3] = 32'h40000000; fr[6] = 32'hC1000000; fr[7] = 32'h3F800000;
    got4.delete();
    for (int i = 0; i < 16; i++) beat4(fr[i]);
    idle(3);
    expect_lit("zero_window", 0, 32'h00000000);
    expect_lit("mixed_window", 1, 32'h40000000);

    // Ramp with random idle gaps.
    got4.delete();
    for (int i = 0; i < 16; i++) begin
      beat4(ramp[i]);
      idle($urandom_range(0, 5));
    end
    idle(3);
    expect_ramp("gapped");

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 7; i++) beat4(ramp[i]);
    do_reset();
    got4.delete();
    for (int i = 0; i < 16; i++) beat4(ramp[i]);
    idle(3);
    expect_ramp("after_reset");

    // Random 4x4 frames, some gapped, some back-to-back.
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 16; i++) begin
        beat4(rand_pix());
        if (f % 2 == 0) idle($urandom_range(0, 2));
      end
    idle(3);

    // Two back-to-back full-size random frames.
    got104_cnt = 0;
    for (int i = 0; i < 2 * N_BIG; i++) beat104(rand_pix());
    idle(3);
    n_checks++;
    if (got104_cnt != 2 * (S_BIG / 2) * (S_BIG / 2)) begin
      n_fail++;
      $display("FAIL big_count: got %0d outputs, expected %0d", got104_cnt, 2 * (S_BIG / 2) * (S_BIG / 2));
    end

    n_checks++;
    if ((q_exp4.size() != 0) || (q_exp104.size() != 0)) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expected outputs never checked, required 0/0",
               q_exp4.size(), q_exp104.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
